// File: rtl/fetch_req_ctrl.sv
// Instruction-fetch request sequencer: owns the fetch PC, issues one ICB fetch at a time,
// drops stale responses after a redirect and holds one fetched instruction toward IF_ID.
module fetch_req_ctrl #(
  parameter int unsigned             PC_WIDTH    = 32,
  parameter int unsigned             INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0]     RESET_PC    = 32'h8000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   redirect_valid_i,
  input  logic [PC_WIDTH-1:0]    redirect_pc_i,
  input  logic [PC_WIDTH-1:0]    pc_next_i,
  output logic [PC_WIDTH-1:0]    fetch_pc_o,
  output logic                   if_req_valid_o,
  input  logic                   if_req_ready_i,
  output logic [PC_WIDTH-1:0]    if_req_pc_o,
  input  logic                   if_resp_valid_i,
  output logic                   if_resp_ready_o,
  input  logic                   if_resp_err_i,
  input  logic [INSTR_WIDTH-1:0] if_resp_instr_i,
  output logic                   ifid_valid_o,
  input  logic                   ifid_ready_i,
  output logic [INSTR_WIDTH-1:0] ifid_instr_o,
  output logic [PC_WIDTH-1:0]    ifid_pc_o,
  output logic                   ifid_err_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_HALT
  } state_t;

  state_t                 state;
  logic [PC_WIDTH-1:0]    pc;
  logic [PC_WIDTH-1:0]    req_pc;
  logic                   drop;
  logic                   out_valid;
  logic [INSTR_WIDTH-1:0] out_instr;
  logic [PC_WIDTH-1:0]    out_pc;
  logic                   out_err;

  logic                   req_hs;
  logic                   resp_hs;
  logic                   take;
  logic [PC_WIDTH-1:0]    pc_nxt;

  assign if_req_valid_o  = (state == ST_REQ);
  assign if_req_pc_o     = req_pc;
  assign if_resp_ready_o = (state == ST_WAIT) & (~out_valid | ifid_ready_i);
  assign fetch_pc_o      = pc;
  assign ifid_valid_o    = out_valid;
  assign ifid_instr_o    = out_instr;
  assign ifid_pc_o       = out_pc;
  assign ifid_err_o      = out_err;

  assign req_hs  = if_req_valid_o & if_req_ready_i;
  assign resp_hs = if_resp_valid_i & if_resp_ready_o;
  assign take    = resp_hs & ~drop;

  always_comb begin
    pc_nxt = pc;
    if (redirect_valid_i) begin
      pc_nxt = redirect_pc_i;
    end else if (take) begin
      pc_nxt = pc_next_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc        <= RESET_PC;
      req_pc    <= RESET_PC;
      drop      <= 1'b0;
      out_valid <= 1'b0;
      out_instr <= '0;
      out_pc    <= '0;
      out_err   <= 1'b0;
    end else begin
      pc <= pc_nxt;
      // A redirect during an unaccepted request keeps the old address on the bus
      // (requests are never withdrawn); the redirect target is fetched afterwards.
      if (!(state == ST_REQ && !req_hs)) begin
        req_pc <= pc_nxt;
      end

      unique case (state)
        ST_IDLE: state <= ST_REQ;
        ST_REQ: begin
          if (redirect_valid_i) begin
            drop <= 1'b1;
          end
          if (req_hs) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (resp_hs) begin
            drop  <= 1'b0;
            state <= (if_resp_err_i && !drop && !redirect_valid_i) ? ST_HALT : ST_REQ;
          end else if (redirect_valid_i) begin
            drop <= 1'b1;
          end
        end
        ST_HALT: begin
          if (redirect_valid_i) begin
            state <= ST_REQ;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (redirect_valid_i) begin
        out_valid <= 1'b0;
      end else if (take) begin
        out_valid <= 1'b1;
        out_instr <= if_resp_instr_i;
        out_pc    <= pc;
        out_err   <= if_resp_err_i;
      end else if (out_valid && ifid_ready_i) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_req_ctrl.sv
// Self-checking bench for fetch_req_ctrl: ICB responder with programmable latency, IF_ID sink,
// and a program-flow reference model checking every instruction delivered to IF_ID.
module tb_fetch_req_ctrl;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic [31:0] pc_next;
  logic [31:0] fetch_pc_o;
  logic        if_req_valid_o;
  logic        if_req_ready_i = 1'b0;
  logic [31:0] if_req_pc_o;
  logic        if_resp_valid_i = 1'b0;
  logic        if_resp_ready_o;
  logic        if_resp_err_i = 1'b0;
  logic [31:0] if_resp_instr_i = '0;
  logic        ifid_valid_o;
  logic        ifid_ready_i = 1'b0;
  logic [31:0] ifid_instr_o;
  logic [31:0] ifid_pc_o;
  logic        ifid_err_o;

  int checks = 0;
  int errors = 0;

  // stimulus configuration
  int unsigned lat = 1;
  int          req_mode = 1;   // 0: never ready, 1: always ready, 2: random
  int          ifid_mode = 1;
  int unsigned req_prob = 50;
  int unsigned ifid_prob = 50;
  logic [31:0] err_addr = 32'h1;
  bit          jump_mode = 1'b0;

  // monitor / model state
  logic [31:0] req_pcs[$];
  int          req_cnt = 0;
  logic [31:0] dl_pc[$];
  logic        dl_err[$];
  logic [31:0] exp_pc = RST_PC;
  bit          halted = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_req_pc = '0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [31:0] step(input logic [31:0] a);
    logic [31:0] m;
    m = mem(a);
    return a + ((jump_mode && m[3]) ? 32'd8 : 32'd4);
  endfunction

  assign pc_next = fetch_pc_o + ((jump_mode && if_resp_instr_i[3]) ? 32'd8 : 32'd4);

  fetch_req_ctrl #(
    .PC_WIDTH    (32),
    .INSTR_WIDTH (32),
    .RESET_PC    (RST_PC)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .pc_next_i        (pc_next),
    .fetch_pc_o       (fetch_pc_o),
    .if_req_valid_o   (if_req_valid_o),
    .if_req_ready_i   (if_req_ready_i),
    .if_req_pc_o      (if_req_pc_o),
    .if_resp_valid_i  (if_resp_valid_i),
    .if_resp_ready_o  (if_resp_ready_o),
    .if_resp_err_i    (if_resp_err_i),
    .if_resp_instr_i  (if_resp_instr_i),
    .ifid_valid_o     (ifid_valid_o),
    .ifid_ready_i     (ifid_ready_i),
    .ifid_instr_o     (ifid_instr_o),
    .ifid_pc_o        (ifid_pc_o),
    .ifid_err_o       (ifid_err_o)
  );

  // ICB responder and IF_ID sink: sample handshakes at negedge, act just after posedge
  initial begin : responder
    bit          s_req_hs;
    bit          s_resp_hs;
    logic [31:0] s_req_pc;
    bit          pend;
    logic [31:0] pend_pc;
    int unsigned cnt;
    pend = 1'b0;
    pend_pc = '0;
    cnt = 0;
    forever begin
      @(negedge clk);
      s_req_hs  = if_req_valid_o && if_req_ready_i;
      s_req_pc  = if_req_pc_o;
      s_resp_hs = if_resp_valid_i && if_resp_ready_o;
      @(posedge clk);
      #1;
      if (!rst_n) begin
        pend = 1'b0;
        if_resp_valid_i = 1'b0;
      end else begin
        if (s_resp_hs) begin
          if_resp_valid_i = 1'b0;
          pend = 1'b0;
        end
        if (s_req_hs) begin
          pend = 1'b1;
          pend_pc = s_req_pc;
          cnt = lat - 1;
        end else if (pend && !if_resp_valid_i && cnt > 0) begin
          cnt--;
        end
        if (pend && !if_resp_valid_i && cnt == 0) begin
          if_resp_valid_i = 1'b1;
          if_resp_instr_i = mem(pend_pc);
          if_resp_err_i   = (pend_pc == err_addr);
        end
      end
      if_req_ready_i = (req_mode == 1) || (req_mode == 2 && $urandom_range(0, 99) < req_prob);
      ifid_ready_i   = (ifid_mode == 1) || (ifid_mode == 2 && $urandom_range(0, 99) < ifid_prob);
    end
  end

  // Monitor: request-hold protocol and program-flow model of the IF_ID stream
  initial begin : monitor
    logic [31:0] m;
    logic        e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_pc = RST_PC;
        halted = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          checks++;
          if (if_req_valid_o !== 1'b1 || if_req_pc_o !== prev_req_pc) begin
            errors++;
            $display("FAIL req_hold: valid=%b pc=%h required valid=1 pc=%h",
                     if_req_valid_o, if_req_pc_o, prev_req_pc);
          end
        end
        prev_stall  = if_req_valid_o && !if_req_ready_i;
        prev_req_pc = if_req_pc_o;
        if (if_req_valid_o && if_req_ready_i) begin
          req_pcs.push_back(if_req_pc_o);
          req_cnt++;
        end
        if (ifid_valid_o && ifid_ready_i) begin
          m = mem(exp_pc);
          e = (exp_pc == err_addr);
          checks++;
          if (halted || ifid_pc_o !== exp_pc || ifid_instr_o !== m || ifid_err_o !== e) begin
            errors++;
            $display("FAIL ifid_stream: pc=%h instr=%h err=%b halted=%0d required pc=%h instr=%h err=%b halted=0",
                     ifid_pc_o, ifid_instr_o, ifid_err_o, halted, exp_pc, m, e);
          end
          dl_pc.push_back(ifid_pc_o);
          dl_err.push_back(ifid_err_o);
          if (e) halted = 1'b1;
          exp_pc = step(exp_pc);
        end
        if (redirect_valid_i) begin
          exp_pc = redirect_pc_i;
          halted = 1'b0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic redirect(input logic [31:0] target);
    @(posedge clk);
    #1;
    redirect_valid_i = 1'b1;
    redirect_pc_i = target;
    @(posedge clk);
    #1;
    redirect_valid_i = 1'b0;
  endtask

  task automatic do_reset(input int unsigned l, input int rm, input int im,
                          input logic [31:0] ea, input bit jm);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    redirect_valid_i = 1'b0;
    lat = l;
    req_mode = rm;
    ifid_mode = im;
    err_addr = ea;
    jump_mode = jm;
    req_pcs.delete();
    dl_pc.delete();
    dl_err.delete();
    req_cnt = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    tick(2);
    checks++;
    if (if_req_valid_o !== 1'b0 || if_resp_ready_o !== 1'b0 || ifid_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_valids: req=%b resp_rdy=%b ifid=%b required 0 0 0",
               if_req_valid_o, if_resp_ready_o, ifid_valid_o);
    end
    checks++;
    if (fetch_pc_o !== RST_PC || if_req_pc_o !== RST_PC) begin
      errors++;
      $display("FAIL reset_pc: fetch_pc=%h req_pc=%h required %h", fetch_pc_o, if_req_pc_o, RST_PC);
    end
    checks++;
    if (ifid_pc_o !== 32'h0 || ifid_instr_o !== 32'h0 || ifid_err_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outreg: pc=%h instr=%h err=%b required 0", ifid_pc_o, ifid_instr_o, ifid_err_o);
    end
    // asynchronous reset while a fetch is in flight
    do_reset(3, 1, 1, 32'h1, 1'b0);
    for (int i = 0; i < 50 && req_cnt < 1; i++) tick(1);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (if_resp_ready_o !== 1'b0 || if_req_valid_o !== 1'b0 || fetch_pc_o !== RST_PC) begin
      errors++;
      $display("FAIL async_reset: resp_rdy=%b req=%b fetch_pc=%h required 0 0 %h",
               if_resp_ready_o, if_req_valid_o, fetch_pc_o, RST_PC);
    end
    tick(3);
  endtask

  task automatic test_sequential;
    do_reset(1, 1, 1, 32'h1, 1'b0);
    for (int i = 0; i < 100 && dl_pc.size() < 3; i++) tick(1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= req_pcs.size() || req_pcs[i] !== RST_PC + 32'(4 * i)) begin
        errors++;
        $display("FAIL seq_req_pc[%0d]: got %h required %h", i,
                 (i < req_pcs.size()) ? req_pcs[i] : 32'hx, RST_PC + 32'(4 * i));
      end
      checks++;
      if (i >= dl_pc.size() || dl_pc[i] !== RST_PC + 32'(4 * i)) begin
        errors++;
        $display("FAIL seq_ifid_pc[%0d]: got %h required %h", i,
                 (i < dl_pc.size()) ? dl_pc[i] : 32'hx, RST_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_backpressure;
    do_reset(1, 1, 0, 32'h1, 1'b0);
    for (int i = 0; i < 50 && !ifid_valid_o; i++) tick(1);
    for (int i = 0; i < 5; i++) begin
      tick(1);
      checks++;
      if (ifid_valid_o !== 1'b1 || ifid_pc_o !== RST_PC || req_cnt > 2) begin
        errors++;
        $display("FAIL bp_hold: ifid_valid=%b pc=%h reqs=%0d required 1 %h <=2",
                 ifid_valid_o, ifid_pc_o, req_cnt, RST_PC);
      end
    end
    checks++;
    if (if_resp_valid_i !== 1'b1 || if_resp_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL bp_resp_stall: resp_valid=%b resp_ready=%b required 1 0", if_resp_valid_i, if_resp_ready_o);
    end
    ifid_mode = 1;
    for (int i = 0; i < 100 && dl_pc.size() < 3; i++) tick(1);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= dl_pc.size() || dl_pc[i] !== RST_PC + 32'(4 * i)) begin
        errors++;
        $display("FAIL bp_order[%0d]: got %h required %h", i,
                 (i < dl_pc.size()) ? dl_pc[i] : 32'hx, RST_PC + 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect_wait;
    do_reset(4, 1, 1, 32'h1, 1'b0);
    for (int i = 0; i < 50 && req_cnt < 1; i++) tick(1);
    redirect(32'h8000_0100);
    for (int i = 0; i < 100 && req_cnt < 2; i++) tick(1);
    checks++;
    if (req_cnt < 2 || req_pcs[1] !== 32'h8000_0100 || dl_pc.size() != 0) begin
      errors++;
      $display("FAIL rw_next_req: reqs=%0d pc=%h delivered=%0d required 2 80000100 0",
               req_cnt, (req_cnt >= 2) ? req_pcs[1] : 32'hx, dl_pc.size());
    end
    for (int i = 0; i < 100 && dl_pc.size() < 1; i++) tick(1);
    checks++;
    if (dl_pc.size() < 1 || dl_pc[0] !== 32'h8000_0100) begin
      errors++;
      $display("FAIL rw_first_ifid: got %h required 80000100", (dl_pc.size() > 0) ? dl_pc[0] : 32'hx);
    end
  endtask

  task automatic test_redirect_same_cycle;
    do_reset(1, 1, 1, 32'h1, 1'b0);
    for (int i = 0; i < 50 && req_cnt < 1; i++) tick(1);
    @(posedge clk);
    #1;
    redirect_valid_i = 1'b1;
    redirect_pc_i = 32'h8000_0240;
    tick(1);
    checks++;
    if (!(if_resp_valid_i && if_resp_ready_o && redirect_valid_i)) begin
      errors++;
      $display("FAIL rs_collide: resp_valid=%b resp_ready=%b redirect=%b required 1 1 1",
               if_resp_valid_i, if_resp_ready_o, redirect_valid_i);
    end
    @(posedge clk);
    #1;
    redirect_valid_i = 1'b0;
    tick(1);
    checks++;
    if (ifid_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rs_flush: ifid_valid=%b required 0", ifid_valid_o);
    end
    for (int i = 0; i < 50 && (req_cnt < 2 || dl_pc.size() < 1); i++) tick(1);
    checks++;
    if (req_cnt < 2 || req_pcs[1] !== 32'h8000_0240 || dl_pc.size() < 1 || dl_pc[0] !== 32'h8000_0240) begin
      errors++;
      $display("FAIL rs_resume: req=%h ifid=%h required 80000240 80000240",
               (req_cnt >= 2) ? req_pcs[1] : 32'hx, (dl_pc.size() > 0) ? dl_pc[0] : 32'hx);
    end
  endtask

  task automatic test_redirect_req_stall;
    do_reset(2, 0, 1, 32'h1, 1'b0);
    tick(3);
    redirect(32'h8000_0300);
    for (int i = 0; i < 3; i++) begin
      tick(1);
      checks++;
      if (if_req_valid_o !== 1'b1 || if_req_pc_o !== RST_PC) begin
        errors++;
        $display("FAIL rq_hold_old: valid=%b pc=%h required 1 %h", if_req_valid_o, if_req_pc_o, RST_PC);
      end
    end
    req_mode = 1;
    for (int i = 0; i < 100 && dl_pc.size() < 1; i++) tick(1);
    checks++;
    if (req_cnt < 2 || req_pcs[0] !== RST_PC || req_pcs[1] !== 32'h8000_0300) begin
      errors++;
      $display("FAIL rq_sequence: reqs=%0d first=%h second=%h required %h 80000300", req_cnt,
               (req_cnt >= 1) ? req_pcs[0] : 32'hx, (req_cnt >= 2) ? req_pcs[1] : 32'hx, RST_PC);
    end
    checks++;
    if (dl_pc.size() < 1 || dl_pc[0] !== 32'h8000_0300) begin
      errors++;
      $display("FAIL rq_first_ifid: got %h required 80000300", (dl_pc.size() > 0) ? dl_pc[0] : 32'hx);
    end
  endtask

  task automatic test_error;
    int rc;
    do_reset(1, 1, 1, 32'h8000_0008, 1'b0);
    for (int i = 0; i < 100 && dl_pc.size() < 3; i++) tick(1);
    checks++;
    if (dl_pc.size() < 3 || dl_pc[2] !== 32'h8000_0008 || dl_err[2] !== 1'b1) begin
      errors++;
      $display("FAIL err_deliver: pc=%h err=%b required 80000008 1",
               (dl_pc.size() >= 3) ? dl_pc[2] : 32'hx, (dl_pc.size() >= 3) ? dl_err[2] : 1'bx);
    end
    rc = req_cnt;
    tick(10);
    checks++;
    if (req_cnt != rc || if_req_valid_o !== 1'b0 || dl_pc.size() != 3) begin
      errors++;
      $display("FAIL err_halt: reqs=%0d->%0d req_valid=%b delivered=%0d required no change 0 3",
               rc, req_cnt, if_req_valid_o, dl_pc.size());
    end
    redirect(32'h8000_0400);
    for (int i = 0; i < 100 && dl_pc.size() < 4; i++) tick(1);
    checks++;
    if (dl_pc.size() < 4 || dl_pc[3] !== 32'h8000_0400 || dl_err[3] !== 1'b0) begin
      errors++;
      $display("FAIL err_resume: pc=%h required 80000400 err=0", (dl_pc.size() >= 4) ? dl_pc[3] : 32'hx);
    end
  endtask

  task automatic test_random;
    int          total;
    logic [31:0] base;
    total = 0;
    for (int seg = 0; seg < 4; seg++) begin
      req_prob  = $urandom_range(30, 100);
      ifid_prob = $urandom_range(30, 100);
      do_reset($urandom_range(1, 4), 2, 2, 32'h8000_0020, 1'b1);
      for (int c = 0; c < 1000; c++) begin
        @(posedge clk);
        #1;
        if ($urandom_range(0, 39) == 0) begin
          base = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFE0 : 32'h8000_0000;
          redirect_valid_i = 1'b1;
          redirect_pc_i = base + 32'($urandom_range(0, 15) * 4);
        end else begin
          redirect_valid_i = 1'b0;
        end
      end
      @(posedge clk);
      #1;
      redirect_valid_i = 1'b0;
      tick(2);
      total += dl_pc.size();
    end
    checks++;
    if (total < 50) begin
      errors++;
      $display("FAIL rand_progress: delivered %0d required at least 50", total);
    end
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_backpressure();
    test_redirect_wait();
    test_redirect_same_cycle();
    test_redirect_req_stall();
    test_error();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
